branch_predict_buf: RTL

Parametrised branch prediction buffer for the superscalar in-order core. It replaces the fixed two-slot predictor. Each cycle it looks up `FETCH_WIDTH` fetch PCs in a tagged, direct-mapped BTB with 2-bit saturating direction counters, and it trains from the single branch resolved at commit. An optional return address stack predicts `jr $ra` targets.

---
 rtl/branch_predict_buf_pkg.sv | 22 ++
 rtl/branch_predict_buf_ras.sv | 34 +++
 rtl/branch_predict_buf.sv | 82 ++++++++
 3 files changed

// File: rtl/branch_predict_buf_pkg.sv
// branch_predict_buf_pkg: shared types, default sizes and counter helper for the branch prediction buffer.
package branch_predict_buf_pkg;
  localparam int BPB_FETCH_WIDTH = 2;
  localparam int BPB_ENTRIES = 64;
  localparam int BPB_TAG_BITS = 10;
  localparam int BPB_RAS_DEPTH = 8;
  typedef struct packed {
    logic hit;
    logic taken;
    logic is_ret;
    logic [31:0] target;
  } bpb_result_t;
  typedef struct packed {
    logic taken;
    logic [31:0] target;
    logic is_call;
    logic is_ret;
  } bpb_commit_t;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
    return up ? (c == 2'b11 ? c : c + 2'd1) : (c == 2'b00 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predict_buf_ras.sv
// branch_predict_buf_ras: circular return address stack; a full push overwrites the oldest entry.
module branch_predict_buf_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] data,
  output logic [31:0] top,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_pop;
  logic [PW:0] count, count_pop;
  logic pop_ok;
  assign empty = count == '0;
  assign top = mem[ptr - PW'(1)];
  assign pop_ok = pop && !empty;
  // A simultaneous pop and push replaces the top: pop first, then push.
  assign ptr_pop = ptr - PW'(pop_ok);
  assign count_pop = count - (PW+1)'(pop_ok);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      count <= '0;
    end else begin
      ptr <= push ? ptr_pop + PW'(1) : ptr_pop;
      count <= push && count_pop != (PW+1)'(DEPTH) ? count_pop + (PW+1)'(1) : count_pop;
    end
  always_ff @(posedge clk)
    if (push) mem[ptr_pop] <= data;
endmodule

// File: rtl/branch_predict_buf.sv
// branch_predict_buf: tagged direct-mapped BTB with 2-bit counters, FETCH_WIDTH lookups, one commit update.
// Define BPB_RAS_EN to add the commit-driven return address stack for is_ret predictions.
module branch_predict_buf
  import branch_predict_buf_pkg::*;
#(
  parameter int FETCH_WIDTH = BPB_FETCH_WIDTH,
  parameter int ENTRIES = BPB_ENTRIES,
  parameter int TAG_BITS = BPB_TAG_BITS,
  parameter int RAS_DEPTH = BPB_RAS_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic [FETCH_WIDTH-1:0][31:0]      pc_predict,
  output bpb_result_t [FETCH_WIDTH-1:0]     destpc_predict,
  input  logic                              wen,
  input  logic [31:0]                       pc_commit,
  input  bpb_commit_t                       destpc_commit
);
  localparam int IDX = $clog2(ENTRIES);
  logic [ENTRIES-1:0] valid, is_ret;
  logic [TAG_BITS-1:0] tag [ENTRIES];
  logic [1:0] ctr [ENTRIES];
  logic [31:0] target [ENTRIES];
  logic [IDX-1:0] c_idx;
  logic [TAG_BITS-1:0] c_tag;
  logic c_hit, c_write, ras_ok, unused_bits;
  logic [31:0] ras_top;
  bpb_result_t lookup [FETCH_WIDTH];
  assign c_idx = pc_commit[IDX+1:2];
  assign c_tag = pc_commit[IDX+TAG_BITS+1:IDX+2];
  assign c_hit = valid[c_idx] && tag[c_idx] == c_tag;
  assign c_write = wen && (c_hit || destpc_commit.taken);
  assign unused_bits = ^{pc_predict, pc_commit, destpc_commit.is_call};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (c_write) begin
      valid[c_idx] <= 1'b1;
      ctr[c_idx] <= c_hit ? ctr_next(ctr[c_idx], destpc_commit.taken) : 2'b10;
    end
  // Payload needs no reset: valid gates every use of it.
  always_ff @(posedge clk) begin
    if (c_write) is_ret[c_idx] <= destpc_commit.is_ret;
    if (wen && !c_hit && destpc_commit.taken) tag[c_idx] <= c_tag;
    if (wen && destpc_commit.taken) target[c_idx] <= destpc_commit.target;
  end
`ifdef BPB_RAS_EN
  logic ras_empty;
  branch_predict_buf_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(wen && destpc_commit.is_call),
    .pop(wen && destpc_commit.is_ret),
    .data(pc_commit + 32'd8),
    .top(ras_top),
    .empty(ras_empty)
  );
  assign ras_ok = !ras_empty;
`else
  assign ras_ok = 1'b0;
  assign ras_top = '0;
`endif
  for (genvar s = 0; s < FETCH_WIDTH; s++) begin : g_slot
    logic [IDX-1:0] idx;
    logic hit, ret;
    assign idx = pc_predict[s][IDX+1:2];
    assign hit = valid[idx] && tag[idx] == pc_predict[s][IDX+TAG_BITS+1:IDX+2];
    assign ret = hit && is_ret[idx];
    assign lookup[s] = '{
      hit: hit,
      taken: hit && (ctr[idx][1] || (ret && ras_ok)),
      is_ret: ret,
      target: !hit ? 32'd0 : (ret && ras_ok) ? ras_top : target[idx]
    };
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) destpc_predict <= '0;
    else if (!stall)
      for (int i = 0; i < FETCH_WIDTH; i++) destpc_predict[i] <= lookup[i];
endmodule
